halut_lut_loader: RTL and testbench
===================================

// Module: halut_lut_loader
// PURPOSE
//  Write-side master for the halut decoder array LUT port. Accepts a valid/ready stream of LUT words and
//  emits the per-unit write port (m_addr, waddr, wdata, we) into halut_decoder_x. Fills a contiguous,
//  wrapping range of decoder units with C*K entries each, linear order waddr = c*K + k.
//  Sits between the DMA/host LUT stream and the decoder array; signals completion to the controller.
// PARAMETERS
//  DecoderUnits   halut_pkg::DecoderUnits   number of decoder units; power of two (address wraps naturally)
//  K              halut_pkg::K              prototypes per codebook
//  C              halut_pkg::C              codebooks
//  DataTypeWidth  halut_pkg::DataTypeWidth  LUT word width
//  TotalAddrWidth $clog2(C*K)               per-unit LUT address width
//  DecAddrWidth   $clog2(DecoderUnits)      decoder unit select width
// PORTS
//  clk_i      in   1                 clock
//  rst_ni     in   1                 reset: asynchronous, active-low
//  start_i    in   1                 begin load; sampled only in IDLE
//  abort_i    in   1                 cancel load; highest priority
//  m_start_i  in   DecAddrWidth      first decoder unit, latched on start
//  m_count_i  in   DecAddrWidth+1    units to fill, latched on start; values >DecoderUnits saturate
//  in_valid_i in   1                 LUT word valid
//  in_data_i  in   DataTypeWidth     LUT word
//  in_ready_o out  1                 loader accepts word
//  m_addr_o   out  DecAddrWidth      decoder unit select -> m_addr_i
//  waddr_o    out  TotalAddrWidth    LUT address -> waddr_i
//  wdata_o    out  DataTypeWidth     LUT data -> wdata_i
//  we_o       out  1                 write strobe -> we_i
//  busy_o     out  1                 high while in LOAD
//  done_o     out  1                 one-cycle pulse: load complete
// BEHAVIOUR
//  - Reset: state IDLE; all outputs and counters 0.
//  - FSM IDLE/LOAD. busy_o = in_ready_o = (state==LOAD), Moore; no combinational path in_valid_i->in_ready_o.
//  - IDLE & start_i & !abort_i at cycle t: latch m_start, count; waddr_cnt=0. count!=0 -> LOAD at t+1.
//    count==0 -> stay IDLE, done_o=1 at t+1, no writes.
//  - Handshake = in_valid_i & in_ready_o at cycle n -> cycle n+1: we_o=1, wdata_o=word, waddr_o=waddr_cnt,
//    m_addr_o=m_cnt. we_o=0 otherwise; other write outputs hold last value (don't-care when we_o=0).
//  - waddr_cnt increments per handshake; at C*K-1 wraps to 0, m_cnt+1 (mod DecoderUnits), units_left-1.
//  - Final handshake (last entry of last unit) at n: state IDLE at n+1; done_o=1 at n+1, same cycle as final
//    we_o. Exactly count*C*K writes per load.
//  - start_i during LOAD: ignored. abort_i in any state: IDLE next cycle, no done_o; handshake in abort cycle
//    is dropped (we_o stays 0). abort_i & start_i same cycle: abort wins.
//  - m_start+count beyond DecoderUnits-1 wraps to unit 0. count==DecoderUnits fills every unit once.
//  - Reset mid-load: immediate IDLE, we_o deasserted asynchronously; partial LUT contents undefined.
// CONFIGURATION
//  HALUT_LOADER_CHECKSUM_EN defined: extra port checksum_o out DataTypeWidth = XOR of all accepted words
//    since last start; cleared on start; final value valid in cycle done_o=1, held until next start; reset 0.
//  Undefined: port and XOR register absent; all other behaviour identical.
// STRUCTURE
//  - halut_pkg: add typedef enum logic {LoaderIdle, LoaderLoad} loader_state_e; reuse K, C, DecoderUnits,
//    DataTypeWidth.
//  - No sub-module: flat FSM + three counters (waddr_cnt, m_cnt, units_left) + output register.
// TESTING (bench params DecoderUnits=4, C=2, K=4 -> 8 entries/unit)
//  1 Reset mid-run -> all outputs 0, busy_o=0, in_ready_o=0 while rst_ni low.
//  2 start m_start=1, m_count=2, 16 words 0x01..0x10 back-to-back -> 16 we_o cycles; unit1 waddr 0..7 data
//    0x01..0x08; unit2 waddr 0..7 data 0x09..0x10; done_o with 16th write; busy_o low next cycle.
//  3 Same as 2, in_valid_i toggles every cycle -> writes only after handshakes; addresses contiguous; 16 writes.
//  4 m_start=3, m_count=2 -> unit 3 waddr 0..7, then unit 0 waddr 0..7; m_count=5 -> saturates, 32 writes.
//  5 abort_i after 5th handshake, with valid on abort cycle -> exactly 5 writes, no done_o, in_ready_o=0 next
//    cycle; restart m_start=0, m_count=1 -> waddr restarts at 0, 8 writes, done_o.
//  6 m_count=0 -> no writes, done_o at t+1; start_i during LOAD ignored; CHECKSUM_EN: words 0x01..0x08 ->
//    checksum_o=0x08.

Source files
------------

// File: rtl/halut_pkg.sv
// -----------------------------------------------------------------------------
// halut_pkg
// Shared configuration for the halut decoder array and its LUT loader.
//   DecoderUnits   number of decoder units (power of two)
//   K              prototypes per codebook
//   C              codebooks
//   DataTypeWidth  LUT word width
//   loader_state_e state encoding of the LUT loader FSM
//   sat_units      clamps a requested unit count to the available units
// -----------------------------------------------------------------------------
package halut_pkg;

    localparam int unsigned DecoderUnits  = 16;
    localparam int unsigned K             = 16;
    localparam int unsigned C             = 32;
    localparam int unsigned DataTypeWidth = 16;

    typedef enum logic {
        LoaderIdle = 1'b0,
        LoaderLoad = 1'b1
    } loader_state_e;

    // A load can never cover more than every unit once.
    function automatic int unsigned sat_units(input int unsigned count,
                                              input int unsigned units);
        return (count > units) ? units : count;
    endfunction

endpackage

// File: rtl/halut_lut_loader.sv
// -----------------------------------------------------------------------------
// halut_lut_loader
// Write-side master for the halut decoder array LUT port. Takes a stream of
// LUT words and writes C*K entries into each of a contiguous, wrapping range
// of decoder units, in linear order waddr = c*K + k.
//
// Optional feature: define HALUT_LOADER_CHECKSUM_EN to add checksum_o, the
// XOR of every word accepted since the last start.
//
// Ports
//   clk_i       clock
//   rst_ni      asynchronous, active-low reset
//   start_i     begin a load (sampled only while idle)
//   abort_i     cancel the load; wins over everything else
//   m_start_i   first decoder unit, latched on start
//   m_count_i   number of units to fill, latched on start (saturates)
//   in_valid_i  LUT word valid
//   in_data_i   LUT word
//   in_ready_o  loader accepts a word this cycle
//   m_addr_o    decoder unit select
//   waddr_o     per-unit LUT address
//   wdata_o     LUT data
//   we_o        write strobe
//   busy_o      load in progress
//   done_o      one-cycle pulse when the load completes
//   state_o     current FSM state (debug)
//   checksum_o  XOR of accepted words (only with HALUT_LOADER_CHECKSUM_EN)
//
// Handshake: a word moves when in_valid_i and in_ready_o are both high at a
// rising clock edge. in_ready_o depends only on registered state, so there is
// no combinational path from in_valid_i to in_ready_o; the producer must hold
// in_valid_i and in_data_i stable until the transfer happens.
// -----------------------------------------------------------------------------
module halut_lut_loader
    import halut_pkg::*;
#(
    parameter int unsigned DecoderUnits   = halut_pkg::DecoderUnits,
    parameter int unsigned K              = halut_pkg::K,
    parameter int unsigned C              = halut_pkg::C,
    parameter int unsigned DataTypeWidth  = halut_pkg::DataTypeWidth,
    parameter int unsigned TotalAddrWidth = $clog2(C * K),
    parameter int unsigned DecAddrWidth   = $clog2(DecoderUnits)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [DecAddrWidth-1:0]   m_start_i,
    input  logic [DecAddrWidth:0]     m_count_i,
    input  logic                      in_valid_i,
    input  logic [DataTypeWidth-1:0]  in_data_i,
    output logic                      in_ready_o,
    output logic [DecAddrWidth-1:0]   m_addr_o,
    output logic [TotalAddrWidth-1:0] waddr_o,
    output logic [DataTypeWidth-1:0]  wdata_o,
    output logic                      we_o,
    output logic                      busy_o,
    output logic                      done_o,
`ifdef HALUT_LOADER_CHECKSUM_EN
    output logic [DataTypeWidth-1:0]  checksum_o,
`endif
    output loader_state_e             state_o
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StLoad = 1'b1;

    localparam int unsigned CountWidth = DecAddrWidth + 1;
    localparam int unsigned Entries    = C * K;

    localparam logic [TotalAddrWidth-1:0] LastEntry = TotalAddrWidth'(Entries - 1);
    localparam logic [CountWidth-1:0]     MaxUnits  = CountWidth'(DecoderUnits);

    logic [0:0]                state;
    logic [DecAddrWidth-1:0]   m_cnt;
    logic [TotalAddrWidth-1:0] waddr_cnt;
    logic [CountWidth-1:0]     units_left;

    logic [DecAddrWidth-1:0]   m_addr_q;
    logic [TotalAddrWidth-1:0] waddr_q;
    logic [DataTypeWidth-1:0]  wdata_q;
    logic                      we_q;
    logic                      done_q;

    logic                      ready;
    logic                      start_go;
    logic                      accept;
    logic                      last_entry;
    logic                      last_unit;
    logic [CountWidth-1:0]     count_sat;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    assign ready      = (state == StLoad);
    // Abort suppresses both a new start and an in-flight transfer.
    assign start_go   = (state == StIdle) && start_i && !abort_i;
    assign accept     = ready && in_valid_i && !abort_i;
    assign last_entry = (waddr_cnt == LastEntry);
    assign last_unit  = (units_left == CountWidth'(1));

    always_comb begin
        count_sat = m_count_i;
        if (m_count_i > MaxUnits) begin
            count_sat = CountWidth'(sat_units(int'(m_count_i), DecoderUnits));
        end
    end

    // ------------------------------------------------------------------
    // FSM and address counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= StIdle;
            m_cnt      <= '0;
            waddr_cnt  <= '0;
            units_left <= '0;
        end else if (abort_i) begin
            state <= StIdle;
        end else begin
            case (state)
                StIdle: begin
                    if (start_go) begin
                        m_cnt      <= m_start_i;
                        waddr_cnt  <= '0;
                        units_left <= count_sat;
                        // A zero-unit load completes immediately from idle.
                        if (count_sat != '0) begin
                            state <= StLoad;
                        end
                    end
                end
                StLoad: begin
                    if (accept) begin
                        if (last_entry) begin
                            waddr_cnt  <= '0;
                            // Unit select wraps modulo DecoderUnits by width.
                            m_cnt      <= m_cnt + DecAddrWidth'(1);
                            units_left <= units_left - CountWidth'(1);
                            if (last_unit) begin
                                state <= StIdle;
                            end
                        end else begin
                            waddr_cnt <= waddr_cnt + TotalAddrWidth'(1);
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write port and completion pulse (registered, one cycle after the
    // handshake). Address/data hold their last value while we_o is low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_addr_q <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            if (accept) begin
                we_q     <= 1'b1;
                m_addr_q <= m_cnt;
                waddr_q  <= waddr_cnt;
                wdata_q  <= in_data_i;
                // done_o lines up with the final write strobe.
                if (last_entry && last_unit) begin
                    done_q <= 1'b1;
                end
            end else if (start_go && (count_sat == '0)) begin
                done_q <= 1'b1;
            end
        end
    end

`ifdef HALUT_LOADER_CHECKSUM_EN
    // ------------------------------------------------------------------
    // Running XOR of accepted words; the value seen with done_o covers the
    // whole load and is held until the next start.
    // ------------------------------------------------------------------
    logic [DataTypeWidth-1:0] checksum_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            checksum_q <= '0;
        end else if (start_go) begin
            checksum_q <= '0;
        end else if (accept) begin
            checksum_q <= checksum_q ^ in_data_i;
        end
    end

    assign checksum_o = checksum_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready_o = ready;
    assign busy_o     = ready;
    assign m_addr_o   = m_addr_q;
    assign waddr_o    = waddr_q;
    assign wdata_o    = wdata_q;
    assign we_o       = we_q;
    assign done_o     = done_q;
    assign state_o    = (state == StLoad) ? LoaderLoad : LoaderIdle;

endmodule

// File: tb/tb_halut_lut_loader.sv
module tb_halut_lut_loader;
  import halut_pkg::*;

  localparam int DU = 4;
  localparam int KK = 4;
  localparam int CC = 2;
  localparam int DW = 8;
  localparam int TA = 3;
  localparam int DA = 2;
  localparam int CW = DA + 1;
  localparam int W  = DA + TA + DW;
  localparam int ENT = CC * KK;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [DA-1:0] m_start_i = '0;
  logic [DA:0]   m_count_i = '0;
  logic          in_valid_i = 1'b0;
  logic [DW-1:0] in_data_i = '0;
  logic          in_ready_o;
  logic [DA-1:0] m_addr_o;
  logic [TA-1:0] waddr_o;
  logic [DW-1:0] wdata_o;
  logic          we_o;
  logic          busy_o;
  logic          done_o;
  loader_state_e state_o;
`ifdef HALUT_LOADER_CHECKSUM_EN
  logic [DW-1:0] checksum_o;
`endif

  halut_lut_loader #(
    .DecoderUnits  (DU),
    .K             (KK),
    .C             (CC),
    .DataTypeWidth (DW),
    .TotalAddrWidth(TA),
    .DecAddrWidth  (DA)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .start_i   (start_i),
    .abort_i   (abort_i),
    .m_start_i (m_start_i),
    .m_count_i (m_count_i),
    .in_valid_i(in_valid_i),
    .in_data_i (in_data_i),
    .in_ready_o(in_ready_o),
    .m_addr_o  (m_addr_o),
    .waddr_o   (waddr_o),
    .wdata_o   (wdata_o),
    .we_o      (we_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
`ifdef HALUT_LOADER_CHECKSUM_EN
    .checksum_o(checksum_o),
`endif
    .state_o   (state_o)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int write_cnt = 0;
  int done_cnt = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ent(input int unit, input int addr, input int data);
    logic [DA-1:0] u;
    logic [TA-1:0] a;
    logic [DW-1:0] d;
    u = DA'(unit % DU);
    a = TA'(addr);
    d = DW'(data);
    return {u, a, d};
  endfunction

  // Every write strobe is matched against the next expected entry.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (we_o) begin
        write_cnt++;
        if (exp_q.size() > 0) check("write", 32'({m_addr_o, waddr_o, wdata_o}), 32'(exp_q.pop_front()));
      end
      if (done_o) done_cnt++;
    end
  end

  // ---------------- driver tasks (called at negedge) ----------------
  task automatic start_load(input int ms, input int mc);
    m_start_i = DA'(ms);
    m_count_i = CW'(mc);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] d);
    int n;
    n = 0;
    in_valid_i = 1'b1;
    in_data_i = d;
    while (!in_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_o) check("handshake_timeout", 32'(in_ready_o), 32'd1);
    @(negedge clk);
  endtask

  // Loads units*ENT words starting at data value first; optional gap cycles.
  task automatic run_load(input int ms, input int units, input int first, input bit gaps);
    int idx;
    idx = 0;
    for (int u = 0; u < units; u++) begin
      for (int a = 0; a < ENT; a++) begin
        exp_q.push_back(ent(ms + u, a, first + idx));
        send_word(DW'(first + idx));
        idx++;
        if (gaps && idx < units * ENT) begin
          in_valid_i = 1'b0;
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic clear_counts();
    write_cnt = 0;
    done_cnt = 0;
    exp_q.delete();
  endtask

  task automatic settle();
    in_valid_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    repeat (2) @(negedge clk);
    check("rst_we", 32'(we_o), 0);
    check("rst_ready", 32'(in_ready_o), 0);
    rst_ni = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy_o), 0);
    check("idle_done", 32'(done_o), 0);

    // 1: reset in the middle of a load
    clear_counts();
    start_load(1, 2);
    send_word(8'hA1);
    send_word(8'hA2);
    send_word(8'hA3);
    check("pre_rst_we", 32'(we_o), 1);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_we", 32'(we_o), 0);
    check("mid_rst_busy", 32'(busy_o), 0);
    check("mid_rst_ready", 32'(in_ready_o), 0);
    check("mid_rst_done", 32'(done_o), 0);
    check("mid_rst_outs", 32'({m_addr_o, waddr_o, wdata_o}), 0);
`ifdef HALUT_LOADER_CHECKSUM_EN
    check("mid_rst_csum", 32'(checksum_o), 0);
`endif
    in_valid_i = 1'b0;
    @(negedge clk);
    check("rst_hold_ready", 32'(in_ready_o), 0);
    rst_ni = 1'b1;
    @(negedge clk);

    // 2: back-to-back, units 1 and 2
    clear_counts();
    start_load(1, 2);
    check("t2_busy", 32'(busy_o), 1);
    run_load(1, 2, 1, 1'b0);
    check("t2_done_with_we", 32'({done_o, we_o}), 32'b11);
    check("t2_last_waddr", 32'(waddr_o), 7);
    check("t2_busy_after", 32'(busy_o), 0);
    settle();
    check("t2_writes", write_cnt, 16);
    check("t2_dones", done_cnt, 1);
    check("t2_exp_left", exp_q.size(), 0);

    // 3: valid toggles every cycle
    clear_counts();
    start_load(1, 2);
    run_load(1, 2, 1, 1'b1);
    check("t3_done_with_we", 32'({done_o, we_o}), 32'b11);
    settle();
    check("t3_writes", write_cnt, 16);
    check("t3_dones", done_cnt, 1);

    // 4: wrap from unit 3 to unit 0, then saturated count
    clear_counts();
    start_load(3, 2);
    run_load(3, 2, 16'h40, 1'b0);
    settle();
    check("t4a_writes", write_cnt, 16);
    check("t4a_dones", done_cnt, 1);
    clear_counts();
    start_load(2, 5);
    run_load(2, 4, 16'h20, 1'b0);
    check("t4b_done", 32'(done_o), 1);
    settle();
    check("t4b_writes", write_cnt, 32);
    check("t4b_dones", done_cnt, 1);
    check("t4b_exp_left", exp_q.size(), 0);

    // 5: abort after 5 handshakes, valid high in the abort cycle
    clear_counts();
    start_load(1, 2);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(ent(1, i, i + 1));
      send_word(DW'(i + 1));
    end
    in_data_i = 8'h99;
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    in_valid_i = 1'b0;
    check("t5_abort_we", 32'(we_o), 0);
    check("t5_abort_ready", 32'(in_ready_o), 0);
    check("t5_abort_busy", 32'(busy_o), 0);
    settle();
    check("t5_writes", write_cnt, 5);
    check("t5_dones", done_cnt, 0);
    clear_counts();
    start_load(0, 1);
    run_load(0, 1, 16'h50, 1'b0);
    check("t5_restart_done", 32'(done_o), 1);
    settle();
    check("t5_restart_writes", write_cnt, 8);
    check("t5_restart_dones", done_cnt, 1);

    // 6: zero-unit load
    clear_counts();
    start_load(2, 0);
    check("t6_zero_done", 32'(done_o), 1);
    check("t6_zero_busy", 32'(busy_o), 0);
    @(negedge clk);
    check("t6_zero_done_pulse", 32'(done_o), 0);
    settle();
    check("t6_zero_writes", write_cnt, 0);
    check("t6_zero_dones", done_cnt, 1);

    // 6: start during a load is ignored
    clear_counts();
    start_load(1, 1);
    exp_q.push_back(ent(1, 0, 1));
    send_word(8'h01);
    exp_q.push_back(ent(1, 1, 2));
    send_word(8'h02);
    in_valid_i = 1'b0;
    start_load(3, 2);
    check("t6_ign_busy", 32'(busy_o), 1);
    for (int i = 2; i < ENT; i++) begin
      exp_q.push_back(ent(1, i, i + 1));
      send_word(DW'(i + 1));
    end
    check("t6_ign_done", 32'(done_o), 1);
`ifdef HALUT_LOADER_CHECKSUM_EN
    check("t6_checksum", 32'(checksum_o), 32'h08);
`endif
    settle();
    check("t6_ign_writes", write_cnt, 8);
    check("t6_ign_dones", done_cnt, 1);
    check("t6_ign_idle", 32'(busy_o), 0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
